// File: rtl/alu16_sequencer_if.sv
// alu16_sequencer_if: request/response handshake and 8-bit ALU bus for the 16-bit sequencer
// Package alu16_sequencer_pkg holds the ALU opcode type shared by the sequencer and its ALU.
// Interface signals:
//   req_valid/req_ready/req_op/req_a/req_b          decoder -> sequencer request
//   rsp_valid/rsp_ready/rsp_result/rsp_flags/_we    sequencer -> consumer response
//   alu_a/alu_b/alu_opcode/alu_enable               sequencer -> ALU drive
//   alu_out/alu_status                              ALU -> sequencer result (combinational)
// Modports: slave = the sequencer, master = the decoder/consumer/ALU side.
package alu16_sequencer_pkg;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC} alu_op;
endpackage

interface alu16_sequencer_if;
  import alu16_sequencer_pkg::*;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [7:0]  rsp_flags;
  logic        rsp_flags_we;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  alu_op       alu_opcode;
  logic        alu_enable;
  logic [7:0]  alu_out;
  logic [7:0]  alu_status;
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_status,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_flags_we,
           alu_a, alu_b, alu_opcode, alu_enable
  );
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready, alu_out, alu_status,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_flags_we,
           alu_a, alu_b, alu_opcode, alu_enable
  );
endinterface

// File: rtl/alu16_sequencer.sv
// alu16_sequencer: runs 16-bit ADD/SUB/INC/DEC as low, high and carry fix-up passes over an 8-bit ALU
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   bus      alu16_sequencer_if.slave: request in, response out, ALU drive and ALU result
// The ALU has no carry-in, so a low-byte carry/borrow on ADD/SUB is applied afterwards
// as an INC/DEC of the high byte; carry and half-carry of that pass are derived from
// the pre-fix high byte rather than taken from the ALU.
module alu16_sequencer (
  input logic               i_clk,
  input logic               i_rst_n,
  alu16_sequencer_if.slave  bus
);
  import alu16_sequencer_pkg::*;
  typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_DONE} state_t;
  state_t      r_state, w_next;
  logic [1:0]  r_op;
  logic [15:0] r_a, r_b;
  logic [7:0]  r_res_lo, r_res_hi;
  logic        r_cy_lo, r_c_hi, r_h_hi, r_c_fix, r_h_fix;
  logic        w_addsub, w_sub, w_cy_lo, w_pv;
  logic [15:0] w_r;
  assign w_addsub = !r_op[1];
  assign w_sub = r_op == 2'd1;
  // Low-byte wrap: ALU carry for ADD/SUB; INC wraps to 00, DEC wraps from 00.
  assign w_cy_lo = w_addsub ? bus.alu_status[0] : r_op[0] ? (r_a[7:0] == 8'h00) : (bus.alu_out == 8'h00);
  assign w_r = {r_res_hi, r_res_lo};
  assign w_pv = (w_sub ? (r_a[15] != r_b[15]) : (r_a[15] == r_b[15])) && (w_r[15] != r_a[15]);
  assign bus.req_ready = r_state == S_IDLE;
  assign bus.rsp_valid = r_state == S_DONE;
  assign bus.rsp_result = w_r;
  assign bus.rsp_flags_we = bus.rsp_valid && w_addsub;
  assign bus.rsp_flags = bus.rsp_flags_we ?
    {w_r[15], w_r == 16'h0000, 1'b0, r_h_hi | r_h_fix, 1'b0, w_pv, w_sub, r_c_hi | r_c_fix} : 8'h00;
  always_comb begin
    w_next = r_state;
    bus.alu_a = 8'h00;
    bus.alu_b = 8'h00;
    bus.alu_opcode = ALU_ADD;
    bus.alu_enable = 1'b0;
    case (r_state)
      S_IDLE: w_next = bus.req_valid ? S_LO : S_IDLE;
      S_LO: begin
        bus.alu_enable = 1'b1;
        bus.alu_a = r_a[7:0];
        bus.alu_b = w_addsub ? r_b[7:0] : 8'h00;
        bus.alu_opcode = alu_op'(r_op);
        w_next = (w_addsub || w_cy_lo) ? S_HI : S_DONE;
      end
      S_HI: begin
        bus.alu_enable = 1'b1;
        bus.alu_a = r_a[15:8];
        bus.alu_b = w_addsub ? r_b[15:8] : 8'h00;
        bus.alu_opcode = alu_op'(r_op);
        w_next = (w_addsub && r_cy_lo) ? S_FIX : S_DONE;
      end
      S_FIX: begin
        bus.alu_enable = 1'b1;
        bus.alu_a = r_res_hi;
        bus.alu_opcode = w_sub ? ALU_DEC : ALU_INC;
        w_next = S_DONE;
      end
      S_DONE: w_next = bus.rsp_ready ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_op <= 2'd0;
      r_a <= 16'h0000;
      r_b <= 16'h0000;
      r_res_lo <= 8'h00;
      r_res_hi <= 8'h00;
      r_cy_lo <= 1'b0;
      r_c_hi <= 1'b0;
      r_h_hi <= 1'b0;
      r_c_fix <= 1'b0;
      r_h_fix <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.req_valid) begin
          r_op <= bus.req_op;
          r_a <= bus.req_a;
          r_b <= bus.req_b;
          r_cy_lo <= 1'b0;
          r_c_hi <= 1'b0;
          r_h_hi <= 1'b0;
          r_c_fix <= 1'b0;
          r_h_fix <= 1'b0;
        end
        S_LO: begin
          r_res_lo <= bus.alu_out;
          r_cy_lo <= w_cy_lo;
          if (!w_addsub && !w_cy_lo) r_res_hi <= r_a[15:8];
        end
        S_HI: begin
          r_res_hi <= bus.alu_out;
          if (w_addsub) begin
            r_c_hi <= bus.alu_status[0];
            r_h_hi <= bus.alu_status[4];
          end
        end
        S_FIX: begin
          r_res_hi <= bus.alu_out;
          r_c_fix <= w_sub ? (r_res_hi == 8'h00) : (r_res_hi == 8'hFF);
          r_h_fix <= w_sub ? (r_res_hi[3:0] == 4'h0) : (r_res_hi[3:0] == 4'hF);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu16_sequencer.sv
// tb_alu16_sequencer: directed vectors with a scoreboard queue checked by an independent response monitor
module tb_alu16_sequencer;
  import alu16_sequencer_pkg::*;
  typedef struct {
    logic [15:0] r;
    logic [7:0]  f;
    logic        we;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int acc_edge = 0;
  int acc_cnt = 0;
  int en_cnt = 0;
  int bad_en = 0;
  bit seen = 1'b0;
  logic [15:0] hold_r;
  logic [7:0]  hold_f;
  exp_t sb[$];
  logic [8:0] alu_s;
  logic [4:0] alu_h;
  logic [7:0] alu_bb;
  logic       alu_sub;
  alu16_sequencer_if bus ();
  alu16_sequencer dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always_comb begin
    alu_sub = (bus.alu_opcode == ALU_SUB) || (bus.alu_opcode == ALU_DEC);
    alu_bb = (bus.alu_opcode == ALU_INC || bus.alu_opcode == ALU_DEC) ? 8'd1 : bus.alu_b;
    alu_s = alu_sub ? {1'b0, bus.alu_a} - {1'b0, alu_bb} : {1'b0, bus.alu_a} + {1'b0, alu_bb};
    alu_h = alu_sub ? {1'b0, bus.alu_a[3:0]} - {1'b0, alu_bb[3:0]} : {1'b0, bus.alu_a[3:0]} + {1'b0, alu_bb[3:0]};
    bus.alu_out = alu_s[7:0];
    bus.alu_status = {alu_s[7], alu_s[7:0] == 8'h00, 1'b0, alu_h[4], 3'b000, alu_s[8]};
  end
  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  always @(posedge clk) begin
    edge_n++;
    if (rst_n && bus.req_valid && bus.req_ready) begin
      acc_edge = edge_n;
      acc_cnt++;
      en_cnt = 0;
    end
  end
  always @(negedge clk) begin
    if (!rst_n) seen = 1'b0;
    else begin
      if (bus.alu_enable) en_cnt++;
      if (bus.alu_enable && (bus.req_ready || bus.rsp_valid)) bad_en++;
      if (bus.rsp_valid && !seen) begin
        exp_t e;
        seen = 1'b1;
        hold_r = bus.rsp_result;
        hold_f = bus.rsp_flags;
        if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", int'(bus.rsp_result), int'(e.r));
          chk("flags", int'(bus.rsp_flags), int'(e.f));
          chk("flags_we", int'(bus.rsp_flags_we), int'(e.we));
          chk("latency", edge_n - acc_edge, e.lat);
          chk("alu_en_cycles", en_cnt, e.lat);
        end
      end else if (bus.rsp_valid) begin
        chk("hold_result", int'(bus.rsp_result), int'(hold_r));
        chk("hold_flags", int'(bus.rsp_flags), int'(hold_f));
      end else seen = 1'b0;
    end
  end
  task automatic issue_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.req_ready && sb.size() == 0) && n < 50);
    if (n >= 50) chk("idle_timeout", n, 0);
  endtask
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] r, input logic [7:0] f, input int lat);
    sb.push_back('{r: r, f: f, we: !op[1], lat: lat});
    issue_req(op, a, b);
    wait_idle();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    int acc0;
    bus.req_valid = 1'b0;
    bus.req_op = 2'd0;
    bus.req_a = 16'h0000;
    bus.req_b = 16'h0000;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_req_ready", int'(bus.req_ready), 1);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_result", int'(bus.rsp_result), 0);
    chk("rst_flags", int'(bus.rsp_flags), 0);
    chk("rst_flags_we", int'(bus.rsp_flags_we), 0);
    chk("rst_alu_en", int'(bus.alu_enable), 0);
    send(2'd0, 16'h00FF, 16'h0001, 16'h0100, 8'h00, 3);
    send(2'd0, 16'hFFFF, 16'h0001, 16'h0000, 8'h51, 3);
    send(2'd0, 16'h7FFF, 16'h0001, 16'h8000, 8'h94, 3);
    send(2'd1, 16'h1000, 16'h0001, 16'h0FFF, 8'h12, 3);
    send(2'd1, 16'h0000, 16'h0001, 16'hFFFF, 8'h93, 3);
    send(2'd0, 16'h1234, 16'h1111, 16'h2345, 8'h00, 2);
    send(2'd1, 16'h5678, 16'h1234, 16'h4444, 8'h02, 2);
    send(2'd0, 16'h8000, 16'h8000, 16'h0000, 8'h45, 2);
    send(2'd2, 16'h1234, 16'hFFFF, 16'h1235, 8'h00, 1);
    send(2'd2, 16'h12FF, 16'h0000, 16'h1300, 8'h00, 2);
    send(2'd3, 16'h0000, 16'h0000, 16'hFFFF, 8'h00, 2);
    send(2'd3, 16'h1234, 16'h0000, 16'h1233, 8'h00, 1);
    bus.rsp_ready = 1'b0;
    sb.push_back('{r: 16'h2345, f: 8'h00, we: 1'b1, lat: 2});
    issue_req(2'd0, 16'h1234, 16'h1111);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", int'(bus.rsp_valid), 1);
    acc0 = acc_cnt;
    bus.req_valid = 1'b1;
    bus.req_op = 2'd2;
    bus.req_a = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_req_ready", int'(bus.req_ready), 0);
      chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
    end
    bus.req_valid = 1'b0;
    chk("bp_not_accepted", acc_cnt, acc0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_idle", int'(bus.req_ready), 1);
    chk("bp_release_valid", int'(bus.rsp_valid), 0);
    issue_req(2'd0, 16'h00FF, 16'h0001);
    @(negedge clk);
    chk("mid_hi_alu_en", int'(bus.alu_enable), 1);
    chk("mid_hi_alu_a", int'(bus.alu_a), 16'h00);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_req_ready", int'(bus.req_ready), 1);
    chk("mid_rst_alu_en", int'(bus.alu_enable), 0);
    chk("mid_rst_rsp_valid", int'(bus.rsp_valid), 0);
    repeat (6) @(negedge clk);
    send(2'd2, 16'h00FF, 16'h0000, 16'h0100, 8'h00, 2);
    chk("sb_empty", sb.size(), 0);
    chk("alu_en_outside", bad_en, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu16_sequencer.md
# alu16_sequencer

Multi-cycle controller that executes 16-bit register-pair arithmetic (ADD16, SUB16, INC16, DEC16) by stepping the shared 8-bit `alu` through a low-byte pass, a high-byte pass and an optional carry/borrow fix-up pass. It sits between the instruction decoder (request side) and the 8-bit ALU, which has no carry-in. It owns the ALU's operand, opcode and enable inputs while busy, and returns a 16-bit result plus composed Z80 flags over a valid/ready handshake.

## Interface
- No parameters; datapath is fixed at 16 bits over an 8-bit ALU.
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 2: 0 ADD16, 1 SUB16, 2 INC16, 3 DEC16.
- `req_a` in 16: first operand (HL / register pair).
- `req_b` in 16: second operand; ignored for INC16/DEC16.
- `rsp_valid` out 1: result available, held until accepted.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_result` out 16: 16-bit result.
- `rsp_flags` out 8: S Z 0 H 0 P/V N C (bit 7 down to bit 0).
- `rsp_flags_we` out 1: 1 for ADD16/SUB16, 0 for INC16/DEC16 (Z80 16-bit INC/DEC leave flags untouched).
- `alu_a`, `alu_b` out 8: ALU operands.
- `alu_opcode` out `alu_op`: ALU operation.
- `alu_enable` out 1: high only in LO, HI and FIX.
- `alu_out` in 8: ALU result (combinational).
- `alu_status` in 8: ALU status flags (combinational).

## Operation
- States: IDLE, LO, HI, FIX, DONE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch `req_op`, `req_a` and `req_b`, then go to LO.
- LO: drives the low bytes.
  - ADD → `ADD(a[7:0], b[7:0])`; SUB → `SUB`; INC → `INC(a[7:0])`; DEC → `DEC(a[7:0])`.
  - Register `res_lo` from `alu_out`.
  - Register `cy_lo`: ADD/SUB use `alu_status[0]`; INC uses (`alu_out`==8'h00); DEC uses (`a[7:0]`==8'h00).
  - Next state: ADD/SUB → HI. INC/DEC → HI if `cy_lo`, else copy `a[15:8]` to `res_hi` and go to DONE.
- HI: drives the high bytes.
  - ADD → `ADD(a[15:8], b[15:8])`; SUB → `SUB`; INC → `INC(a[15:8])`; DEC → `DEC(a[15:8])`.
  - Register `res_hi` from `alu_out`.
  - ADD/SUB also register `c_hi` = `alu_status[0]` and `h_hi` = `alu_status[4]`.
  - Next state: FIX if (ADD/SUB and `cy_lo`), else DONE.
- FIX: propagates the low-byte carry or borrow.
  - Drive `INC(res_hi)` for ADD or `DEC(res_hi)` for SUB; `alu_b` = 0.
  - `c_fix`: ADD → (`res_hi`==8'hFF); SUB → (`res_hi`==8'h00). Computed from the pre-fix value.
  - `h_fix`: ADD → (`res_hi[3:0]`==4'hF); SUB → (`res_hi[3:0]`==4'h0).
  - Register `alu_out` into `res_hi`, then go to DONE.
  - When FIX is skipped, `c_fix` and `h_fix` are 0.
- DONE:
  - `rsp_valid`=1; `rsp_result`={`res_hi`,`res_lo`}.
  - On `rsp_ready`, go to IDLE.
  - No new request is accepted in the same cycle.
- Flag composition (ADD16/SUB16; r = final result):
  - C = `c_hi` | `c_fix`.
  - H = `h_hi` | `h_fix`.
  - S = r[15]; Z = (r==0); N = 1 for SUB16, else 0.
  - P/V for ADD: (a15==b15)&&(r15!=a15). P/V for SUB: (a15!=b15)&&(r15!=a15).
  - Bits 5 and 3 are 0.
  - For INC16/DEC16, `rsp_flags`=8'h00 and `rsp_flags_we`=0.
- Inputs `alu_out` and `alu_status` are sampled only in LO, HI and FIX.
- Outside those states: `alu_a`=0, `alu_b`=0, `alu_opcode`=ADD, `alu_enable`=0.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state=IDLE; `rsp_valid`=0; `rsp_result`=0; `rsp_flags`=0; `rsp_flags_we`=0; `alu_enable`=0; all internal registers cleared.
  - `req_ready`=1 in the first cycle after reset is released.
- Reset has priority over everything. Asserting it in any state aborts the operation, and no response is produced.
- Latency, counting the edge that accepts the request as E0:
  - ADD16/SUB16 without fix: `rsp_valid` from E2.
  - ADD16/SUB16 with fix: `rsp_valid` from E3.
  - INC16/DEC16 without low-byte wrap: `rsp_valid` from E1.
  - INC16/DEC16 with low-byte wrap: `rsp_valid` from E2.
- While `rsp_valid`=1 and `rsp_ready`=0, the `rsp_*` outputs hold stable indefinitely and `req_ready`=0.
- `rsp_ready` asserted while `rsp_valid`=0 has no effect.
- Back-to-back throughput: at best one request every (latency + 2) cycles. This covers DONE→IDLE plus acceptance.

## Test plan
- ADD16 0x00FF+0x0001 → result 0x0100, FIX visited, `rsp_valid` from E3, flags 0x00, `rsp_flags_we`=1.
- ADD16 0xFFFF+0x0001 → result 0x0000, flags 0x51 (Z, H, C); ADD16 0x7FFF+0x0001 → result 0x8000, flags 0x94 (S, H, P/V).
- SUB16 0x1000−0x0001 → result 0x0FFF, flags 0x12 (H, N); SUB16 0x0000−0x0001 → result 0xFFFF, flags 0x93 (S, H, N, C).
- INC16 0x1234 → 0x1235 at E1; INC16 0x12FF → 0x1300 at E2; DEC16 0x0000 → 0xFFFF at E2. All with `rsp_flags_we`=0. `alu_enable` is high exactly in LO/HI/FIX cycles.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` → outputs stable, `req_ready`=0 and a pending `req_valid` is not accepted. Release → IDLE the next cycle.
- Reset mid-operation: drive `rst_n`=0 for one edge while in HI → `rsp_valid` never asserts for that request, `alu_enable`=0 and `req_ready`=1 after release.
